// File: rtl/step_cmd_gen_if.sv
// rtl/step_cmd_gen_if.sv - move request and status bundle between the control FSM and step_cmd_gen
interface step_cmd_gen_if #(
  parameter int CNT_W = 8,
  parameter int DIV_W = 8
);
  logic             start;
  logic             dir;
  logic [CNT_W-1:0] steps;
  logic [DIV_W-1:0] period;
  logic             abort;
  logic             step;
  logic             M;
  logic             busy;
  logic             done;
  logic             aborted;
  logic [CNT_W-1:0] remaining;

  modport master (
    output start, dir, steps, period, abort,
    input  step, M, busy, done, aborted, remaining
  );

  modport slave (
    input  start, dir, steps, period, abort,
    output step, M, busy, done, aborted, remaining
  );
endinterface

// File: rtl/step_cmd_gen.sv
// rtl/step_cmd_gen.sv - relative-move command stage issuing paced step strobes and a held direction
module step_cmd_gen #(
  parameter int CNT_W = 8,
  parameter int DIV_W = 8
) (
  input  logic         CP,
  input  logic         CR,
  step_cmd_gen_if.slave bus
);

  typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

  state_t           state, state_n;
  logic [DIV_W-1:0] div, div_n;
  logic [DIV_W-1:0] per, per_n;
  logic [CNT_W-1:0] rem, rem_n;
  logic             m_q, m_n;
  logic             ab, ab_n;
  logic             stp, stp_n;

  always_ff @(posedge CP) begin
    if (CR) begin
      state <= IDLE;
      div   <= '0;
      per   <= '0;
      rem   <= '0;
      m_q   <= 1'b0;
      ab    <= 1'b0;
      stp   <= 1'b0;
    end else begin
      state <= state_n;
      div   <= div_n;
      per   <= per_n;
      rem   <= rem_n;
      m_q   <= m_n;
      ab    <= ab_n;
      stp   <= stp_n;
    end
  end

  always_comb begin
    state_n = state;
    div_n   = div;
    per_n   = per;
    rem_n   = rem;
    m_n     = m_q;
    ab_n    = ab;
    stp_n   = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) begin
          ab_n = 1'b0;
          if (bus.steps != '0) begin
            per_n   = bus.period;
            rem_n   = bus.steps;
            m_n     = bus.dir;
            div_n   = '0;
            state_n = RUN;
          end else begin
            state_n = FIN;
          end
        end
      end
      RUN: begin
        // abort outranks a pending strobe; rem==0 here means the last strobe is on the wire
        if (bus.abort) begin
          ab_n    = 1'b1;
          state_n = FIN;
        end else if (rem == '0) begin
          state_n = FIN;
        end else if (div == per) begin
          div_n = '0;
          stp_n = 1'b1;
          rem_n = rem - CNT_W'(1);
        end else begin
          div_n = div + DIV_W'(1);
        end
      end
      FIN: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  assign bus.step      = stp;
  assign bus.M         = m_q;
  assign bus.busy      = (state == RUN);
  assign bus.done      = (state == FIN);
  assign bus.aborted   = ab;
  assign bus.remaining = rem;

endmodule

// File: tb/tb_step_cmd_gen.sv
// tb/tb_step_cmd_gen.sv - bench for step_cmd_gen: per-cycle move model plus directed timing checks
module tb_step_cmd_gen;

  logic CP = 1'b0;
  logic CR = 1'b1;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_err = 0;

  step_cmd_gen_if #(.CNT_W(8), .DIV_W(8)) bus ();

  step_cmd_gen #(.CNT_W(8), .DIV_W(8)) dut (
    .CP (CP),
    .CR (CR),
    .bus(bus)
  );

  always #5 CP = ~CP;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Move model: j counts cycles since the accepting edge (j=1 is the first cycle after it)
  int m_mode = 0;  // 0 idle, 1 moving, 2 finishing
  int m_j = 0, m_p = 0, m_n = 0, m_rem = 0, m_dir = 0, m_ab = 0;

  function automatic int run_rem();
    return m_n - (m_j - 1) / (m_p + 1);
  endfunction

  always @(posedge CP) begin
    cyc <= cyc + 1;
    if (CR) begin
      m_mode = 0; m_rem = 0; m_dir = 0; m_ab = 0;
    end else begin
      case (m_mode)
        0: if (bus.start) begin
          m_ab = 0;
          if (bus.steps != 0) begin
            m_mode = 1; m_j = 1; m_p = int'(bus.period); m_n = int'(bus.steps); m_dir = int'(bus.dir);
          end else begin
            m_mode = 2;
          end
        end
        1: begin
          if (bus.abort) begin
            m_rem = run_rem(); m_ab = 1; m_mode = 2;
          end else if (m_j == 1 + m_n * (m_p + 1)) begin
            m_rem = 0; m_mode = 2;
          end else begin
            m_j++;
          end
        end
        default: m_mode = 0;
      endcase
    end
  end

  always @(negedge CP) begin
    if (cyc > 0) begin
      check("model_step", int'(bus.step),
            (m_mode == 1 && m_j > 1 && ((m_j - 1) % (m_p + 1)) == 0) ? 1 : 0);
      check("model_busy", int'(bus.busy), (m_mode == 1) ? 1 : 0);
      check("model_done", int'(bus.done), (m_mode == 2) ? 1 : 0);
      check("model_M", int'(bus.M), m_dir);
      check("model_aborted", int'(bus.aborted), m_ab);
      check("model_remaining", int'(bus.remaining), (m_mode == 1) ? run_rem() : m_rem);
    end
  end

  // Presents a request for one edge; returns at the negedge of cycle j=1
  task automatic go(input logic d, input int n, input int p);
    bus.start = 1'b1; bus.dir = d; bus.steps = 8'(n); bus.period = 8'(p);
    @(negedge CP);
    bus.start = 1'b0;
  endtask

  int strobes;

  initial begin
    bus.start = 1'b1; bus.dir = 1'b1; bus.steps = 8'd3; bus.period = 8'd0; bus.abort = 1'b0;
    repeat (2) @(negedge CP);
    check("rst_step", int'(bus.step), 0);
    check("rst_busy", int'(bus.busy), 0);
    check("rst_M", int'(bus.M), 0);
    check("rst_done", int'(bus.done), 0);
    CR = 1'b0; bus.start = 1'b0;
    repeat (2) @(negedge CP);
    check("idle_remaining", int'(bus.remaining), 0);
    check("idle_busy", int'(bus.busy), 0);

    // basic move: strobes at t+4, t+7, t+10, done t+11
    go(1'b1, 3, 2);
    for (int j = 1; j <= 12; j++) begin
      check("basic_step", int'(bus.step), (j == 4 || j == 7 || j == 10) ? 1 : 0);
      check("basic_done", int'(bus.done), (j == 11) ? 1 : 0);
      check("basic_busy", int'(bus.busy), (j <= 10) ? 1 : 0);
      check("basic_rem", int'(bus.remaining), (j < 4) ? 3 : (j < 7) ? 2 : (j < 10) ? 1 : 0);
      if (j <= 10) check("basic_M", int'(bus.M), 1);
      @(negedge CP);
    end

    // back-to-back strobes at period 0
    go(1'b0, 4, 0);
    for (int j = 1; j <= 7; j++) begin
      check("b2b_step", int'(bus.step), (j >= 2 && j <= 5) ? 1 : 0);
      check("b2b_done", int'(bus.done), (j == 6) ? 1 : 0);
      check("b2b_M", int'(bus.M), 0);
      if (j < 7) @(negedge CP);
    end
    go(1'b1, 1, 0);
    check("b2b_M_new", int'(bus.M), 1);
    repeat (4) @(negedge CP);

    // abort on the edge that would fire the second strobe
    strobes = 0;
    go(1'b1, 5, 3);
    for (int j = 1; j <= 10; j++) begin
      strobes += int'(bus.step);
      bus.abort = (j == 8);
      if (j == 9) begin
        check("abort_done", int'(bus.done), 1);
        check("abort_flag", int'(bus.aborted), 1);
        check("abort_rem", int'(bus.remaining), 4);
      end
      @(negedge CP);
    end
    check("abort_strobes", strobes, 1);
    bus.abort = 1'b1;
    repeat (3) @(negedge CP);
    bus.abort = 1'b0;
    check("abort_idle_held", int'(bus.aborted), 1);

    // zero-step move, then a start pulse ignored mid-move
    go(1'b0, 0, 5);
    check("zero_done", int'(bus.done), 1);
    check("zero_busy", int'(bus.busy), 0);
    check("zero_aborted", int'(bus.aborted), 0);
    @(negedge CP);
    go(1'b1, 2, 1);
    for (int j = 1; j <= 7; j++) begin
      bus.start = (j == 2); bus.dir = 1'b0; bus.steps = 8'd7; bus.period = 8'd0;
      check("ign_step", int'(bus.step), (j == 3 || j == 5) ? 1 : 0);
      check("ign_done", int'(bus.done), (j == 6) ? 1 : 0);
      if (j <= 5) check("ign_M", int'(bus.M), 1);
      @(negedge CP);
    end
    bus.start = 1'b0;
    @(negedge CP);

    // reset after the first strobe
    go(1'b1, 6, 1);
    for (int j = 1; j <= 5; j++) begin
      CR = (j == 3);
      if (j == 4) begin
        check("rstmid_busy", int'(bus.busy), 0);
        check("rstmid_rem", int'(bus.remaining), 0);
        check("rstmid_step", int'(bus.step), 0);
      end
      if (j >= 4) check("rstmid_done", int'(bus.done), 0);
      @(negedge CP);
    end
    CR = 1'b0;
    go(1'b0, 2, 0);
    for (int j = 1; j <= 5; j++) begin
      check("post_step", int'(bus.step), (j == 2 || j == 3) ? 1 : 0);
      check("post_done", int'(bus.done), (j == 4) ? 1 : 0);
      @(negedge CP);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule

// File: doc/step_cmd_gen.md
Name: step_cmd_gen

Overview:
- Upstream command stage for the three-phase stepper sequencer.
- Accepts a relative move request (step count, direction, step period) and emits a registered one-cycle step strobe at a programmable rate, plus a stable direction level M.
- The stepper sequencer advances one phase state per strobe and uses M as its direction input.
- Provides busy/done status and an abort path for the control FSM above it.

Parameters:
CNT_W, 8, width of step count and remaining-step counter
DIV_W, 8, width of step-period divider

Ports:
CP  input  1  system clock, all logic on rising edge
CR  input  1  reset, synchronous, active-high
start  input  1  move request, sampled only in IDLE
dir  input  1  requested direction, latched on accept (1 = forward)
steps  input  CNT_W  number of step strobes for the move
period  input  DIV_W  step interval minus one, in CP cycles
abort  input  1  terminate current move
step  output  1  one-cycle step strobe to sequencer
M  output  1  latched direction to sequencer
busy  output  1  move in progress
done  output  1  one-cycle end-of-move pulse
aborted  output  1  last move ended by abort; held until next accept
remaining  output  CNT_W  steps still to issue

Behaviour:
- One clock, CP. Reset CR is synchronous and active-high.
- Reset (CR=1 at a CP edge): state IDLE; step=0, M=0, busy=0, done=0, aborted=0, remaining=0, divider=0. CR overrides every other input, including mid-move; no strobe or done is produced for a reset-killed move.
- States: IDLE, RUN, FIN.
- IDLE, start=1 at edge t, steps!=0:
  - latch P=period, remaining=steps, M=dir; clear aborted; divider=0.
  - enter RUN; busy=1 from cycle t+1.
- IDLE, start=1 at edge t, steps==0:
  - enter FIN; busy stays 0; M unchanged; aborted cleared.
  - done=1 in cycle t+1.
- RUN:
  - divider increments each cycle.
  - When divider==P: divider returns to 0, step=1 for the next cycle, remaining decrements.
  - First strobe is high in cycle t+2+P. Later strobes follow every P+1 cycles.
  - P=0 gives a strobe every cycle.
  - Direction changes only take effect through a new accept.
- Strobe that drives remaining to 0: go to FIN. In the next cycle done=1 and busy=0, so busy is high from t+1 through the cycle of the last strobe.
- FIN: lasts exactly one cycle (done=1, step=0), then IDLE. A start in FIN is ignored.
- abort=1 in RUN:
  - enter FIN; aborted=1; no further strobes; remaining holds its current value.
  - If abort coincides with the divider==P edge, abort wins: no strobe and no decrement.
  - A strobe already high in the abort cycle is not retracted.
- abort in IDLE or FIN: ignored.
- start while busy: ignored; the latched parameters are unchanged.
- step and done are never high in the same cycle. M is stable whenever busy=1 or step=1.
- remaining wraps never: the decrement happens only when remaining is nonzero.
- Counters are unsigned, with no saturation logic needed.

Test Plan:
- Reset then idle: CR=1 two cycles with start=1 → all outputs 0, no strobe; after CR=0, remaining=0 and busy=0.
- Basic move: accept at t with steps=3, period=2, dir=1 → M=1 from t+1; step high at t+4, t+7, t+10; done at t+11; busy high t+1..t+10; remaining goes 3→2→1→0.
- Back-to-back rate: steps=4, period=0, dir=0 → step high t+2..t+5 consecutively, done at t+6; then start again with dir=1 → M flips only at the new accept.
- Abort collision: steps=5, period=3, abort asserted on the edge where the 2nd strobe would fire → exactly 1 strobe, done next cycle, aborted=1, remaining=4.
- Zero-step and ignored start: steps=0 → done at t+1, busy never high, no strobe; during a steps=2 move, pulse start with dir flipped → M, remaining and the strobe schedule are unaffected.
- Reset mid-move: CR=1 after the 1st strobe of a steps=6 move → next cycle busy=0, remaining=0, no done; a new move accepts normally afterward.
